// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for pc..ex_mem pipeline registers; stall/flush are combinational
// from inputs and state, exception redirect one cycle after trigger. Optional PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES   = 32,
    parameter int EXC_VECTOR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id2_load_use,
    input  logic                    ex_div_start,
    input  logic                    ex_branch_redirect,
    input  logic [EXC_VECTOR_W-1:0] ex_branch_target,
    input  logic                    mem_exception,
    input  logic [EXC_VECTOR_W-1:0] mem_exc_target,
    input  logic                    dcache_stall,
    output logic [4:0]              stall,
    output logic [4:0]              flush,
    output logic                    exception_flush,
    output logic                    pc_redirect_ena,
    output logic [EXC_VECTOR_W-1:0] pc_redirect_addr,
    output logic                    div_busy,
    output logic                    div_done
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_stall_cycles,
    output logic [15:0]             perf_exc_count
`endif
);

    typedef enum logic [1:0] {RUN, EXC_PEND, EXC_FIRE} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t                  state;
    logic [5:0]              div_cnt;
    logic [EXC_VECTOR_W-1:0] exc_target;

    logic div_start_ok;
    logic div_occ;
    logic div_freeze;

    assign div_start_ok = ex_div_start && (div_cnt == 6'd0);
    assign div_occ      = (div_cnt > 6'd1) || div_start_ok;
    // The whole pipe is frozen by a miss or a pending exception, so the divide makes no progress.
    assign div_freeze   = dcache_stall || (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            div_cnt    <= 6'd0;
            exc_target <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_exception) begin
                        exc_target <= mem_exc_target;
                        state      <= dcache_stall ? EXC_PEND : EXC_FIRE;
                    end
                end
                EXC_PEND: begin
                    if (!dcache_stall)
                        state <= EXC_FIRE;
                end
                EXC_FIRE: state <= RUN;
                default:  state <= RUN;
            endcase

            if (state == EXC_FIRE)
                div_cnt <= 6'd0;
            else if (!div_freeze) begin
                if (div_start_ok)
                    div_cnt <= DIV_LOAD;
                else if (div_cnt != 6'd0)
                    div_cnt <= div_cnt - 6'd1;
            end
        end
    end

    always_comb begin
        stall            = 5'b00000;
        flush            = 5'b00000;
        exception_flush  = 1'b0;
        pc_redirect_ena  = 1'b0;
        pc_redirect_addr = '0;
        div_busy         = 1'b0;
        div_done         = 1'b0;
        if (!rst) begin
            case (state)
                EXC_FIRE: begin
                    exception_flush  = 1'b1;
                    pc_redirect_ena  = 1'b1;
                    pc_redirect_addr = exc_target;
                    flush            = 5'b11111;
                end
                EXC_PEND: stall = 5'b11111;
                default: begin
                    div_busy = div_occ;
                    div_done = (div_cnt == 6'd1);
                    // load_use outranks a branch, which also covers the illegal both-high case.
                    if (dcache_stall) begin
                        stall = 5'b11111;
                    end else if (div_occ) begin
                        stall = 5'b01111;
                        flush = 5'b10000;
                    end else if (id2_load_use) begin
                        stall = 5'b00111;
                        flush = 5'b01000;
                    end else if (ex_branch_redirect) begin
                        flush            = 5'b00110;
                        pc_redirect_ena  = 1'b1;
                        pc_redirect_addr = ex_branch_target;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_exc_count    <= '0;
        end else begin
            if (stall[0] && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if ((state == EXC_FIRE) && (perf_exc_count != '1))
                perf_exc_count <= perf_exc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random stimulus for pipe_hazard_ctrl, checked every cycle against a
// behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id2_load_use, ex_div_start, ex_branch_redirect;
    logic [31:0] ex_branch_target;
    logic        mem_exception;
    logic [31:0] mem_exc_target;
    logic        dcache_stall;
    logic [4:0]  stall, flush;
    logic        exception_flush, pc_redirect_ena;
    logic [31:0] pc_redirect_addr;
    logic        div_busy, div_done;

    pipe_hazard_ctrl #(.DIV_CYCLES(N), .EXC_VECTOR_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .id2_load_use       (id2_load_use),
        .ex_div_start       (ex_div_start),
        .ex_branch_redirect (ex_branch_redirect),
        .ex_branch_target   (ex_branch_target),
        .mem_exception      (mem_exception),
        .mem_exc_target     (mem_exc_target),
        .dcache_stall       (dcache_stall),
        .stall              (stall),
        .flush              (flush),
        .exception_flush    (exception_flush),
        .pc_redirect_ena    (pc_redirect_ena),
        .pc_redirect_addr   (pc_redirect_addr),
        .div_busy           (div_busy),
        .div_done           (div_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state: exception bookkeeping and divide position (EX cycles already spent).
    bit          m_pending, m_fire, m_in_div;
    int          m_pos;
    logic [31:0] m_target;

    task automatic chk(input string phase, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s: got %h expected %h", phase, field, obs, exp);
    endtask

    task automatic model_check(input string phase);
        logic [4:0]  e_stall = '0, e_flush = '0;
        logic        e_ef = 1'b0, e_pe = 1'b0, e_busy = 1'b0, e_done = 1'b0;
        logic [31:0] e_addr = '0;
        if (!rst) begin
            if (m_fire) begin
                e_ef = 1'b1; e_pe = 1'b1; e_addr = m_target; e_flush = 5'b11111;
            end else if (m_pending) begin
                e_stall = 5'b11111;
            end else begin
                e_busy = (m_in_div && m_pos < N - 1) || (!m_in_div && ex_div_start);
                e_done = m_in_div && m_pos == N - 1;
                if (dcache_stall)            e_stall = 5'b11111;
                else if (e_busy)             begin e_stall = 5'b01111; e_flush = 5'b10000; end
                else if (id2_load_use)       begin e_stall = 5'b00111; e_flush = 5'b01000; end
                else if (ex_branch_redirect) begin e_flush = 5'b00110; e_pe = 1'b1; e_addr = ex_branch_target; end
            end
        end
        chk(phase, "stall", {27'd0, stall}, {27'd0, e_stall});
        chk(phase, "flush", {27'd0, flush}, {27'd0, e_flush});
        chk(phase, "exception_flush", {31'd0, exception_flush}, {31'd0, e_ef});
        chk(phase, "pc_redirect_ena", {31'd0, pc_redirect_ena}, {31'd0, e_pe});
        chk(phase, "pc_redirect_addr", pc_redirect_addr, e_addr);
        chk(phase, "div_busy", {31'd0, div_busy}, {31'd0, e_busy});
        chk(phase, "div_done", {31'd0, div_done}, {31'd0, e_done});
    endtask

    task automatic model_update();
        if (rst) begin
            m_pending = 0; m_fire = 0; m_in_div = 0; m_pos = 0; m_target = '0;
        end else if (m_fire) begin
            m_fire = 0; m_in_div = 0; m_pos = 0;
        end else if (m_pending) begin
            if (!dcache_stall) begin m_pending = 0; m_fire = 1; end
        end else begin
            if (mem_exception) begin
                m_target = mem_exc_target;
                if (dcache_stall) m_pending = 1; else m_fire = 1;
            end
            if (!dcache_stall) begin
                if (m_in_div) begin
                    m_pos++;
                    if (m_pos == N) m_in_div = 0;
                end else if (ex_div_start) begin
                    m_in_div = 1; m_pos = 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic ds, input logic br,
                        input logic [31:0] bt, input logic me, input logic [31:0] mt,
                        input logic dc, input string phase);
        @(negedge clk);
        rst = r; id2_load_use = ld; ex_div_start = ds; ex_branch_redirect = br;
        ex_branch_target = bt; mem_exception = me; mem_exc_target = mt; dcache_stall = dc;
        #2;
        model_check(phase);
        @(posedge clk);
        model_update();
    endtask

    initial begin
        m_pending = 0; m_fire = 0; m_in_div = 0; m_pos = 0; m_target = '0;
        // Reset with noisy inputs: outputs must stay low.
        step(1, 1, 1, 1, 32'h1234_5678, 1, 32'h8765_4321, 1, "reset");
        step(1, 0, 0, 1, 32'h1234_5678, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, "idle");

        step(0, 1, 0, 0, 0, 0, 0, 0, "load_use");
        step(0, 0, 0, 0, 0, 0, 0, 0, "load_use_after");

        for (int i = 0; i < N; i++) step(0, 0, 1, 0, 0, 0, 0, 0, "divide");
        step(0, 0, 0, 0, 0, 0, 0, 0, "divide_after");
        // Divide frozen by a miss in its second cycle.
        step(0, 0, 1, 0, 0, 0, 0, 0, "div_miss");
        step(0, 0, 1, 1, 32'h0000_4000, 0, 0, 1, "div_miss");
        step(0, 0, 1, 0, 0, 0, 0, 1, "div_miss");
        for (int i = 0; i < N; i++) step(0, 0, 1, 0, 0, 0, 0, 0, "div_miss");
        step(0, 0, 0, 0, 0, 0, 0, 0, "div_miss_after");

        step(0, 0, 0, 0, 0, 1, 32'hBFC0_0380, 1, "exc_miss");
        step(0, 0, 0, 0, 0, 1, 32'hDEAD_0000, 1, "exc_miss");
        step(0, 0, 0, 1, 32'h1111_0000, 0, 0, 1, "exc_miss");
        step(0, 0, 0, 0, 0, 0, 0, 1, "exc_miss");
        step(0, 0, 0, 0, 0, 0, 0, 0, "exc_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, "exc_fire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "exc_after");

        step(0, 0, 0, 1, 32'h8000_1000, 0, 0, 0, "branch");
        step(0, 0, 0, 1, 32'h8000_2000, 0, 0, 1, "branch_miss");
        step(0, 1, 0, 1, 32'h8000_3000, 0, 0, 0, "branch_ld");
        step(0, 0, 0, 0, 0, 0, 0, 0, "branch_after");

        step(0, 0, 1, 0, 0, 0, 0, 0, "exc_div");
        step(0, 0, 1, 0, 0, 1, 32'h8000_0180, 0, "exc_div");
        step(0, 0, 0, 0, 0, 0, 0, 0, "exc_div_fire");
        for (int i = 0; i < N; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "exc_div_after");

        step(0, 0, 0, 0, 0, 1, 32'hBFC0_0200, 1, "rst_pend");
        step(0, 0, 0, 0, 0, 0, 0, 1, "rst_pend");
        step(1, 0, 0, 0, 0, 0, 0, 1, "rst_pend_rst");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "rst_pend_after");

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 25,
                 $urandom,
                 $urandom_range(0, 99) < 6,
                 $urandom,
                 $urandom_range(0, 99) < 25,
                 "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
